// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths, CP0 addresses, exception codes and the
// memory-to-writeback bus layout used by the write-back stage and CP0.
package wb_stage_pkg;

  localparam int MS_TO_WS_BUS_WD = 155;
  localparam int WS_TO_RF_BUS_WD = 41;

  // CP0 addresses as {rd[4:0], sel[2:0]}
  localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // MSB first: ex sits at bit 154, pc at [31:0]
  typedef struct packed {
    logic        ex;
    logic [4:0]  exccode;
    logic        bd;
    logic [31:0] badvaddr;
    logic        eret;
    logic        mtc0;
    logic [7:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        res_from_cp0;
    logic [3:0]  rf_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_ws_bus_t;

endpackage

// File: rtl/wb_stage_cp0_regs.sv
// cp0_regs: CP0 register file for the write-back stage.
//   clk/reset      : clock, synchronous active-high reset
//   ext_int_i      : level-sensitive hardware interrupt lines
//   ex_i..badvaddr_i : exception commit and its attributes
//   eret_i         : ERET commit (already excludes an exception)
//   mtc0_we_i, addr_i, wdata_i : gated MTC0 write
//   rdata_o        : combinational read of addr_i (0 if unimplemented)
//   epc_o          : EPC for the ERET redirect
//   int_req_o      : an enabled interrupt is pending
module cp0_regs
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] CP0_STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  ext_int_i,
  input  logic        ex_i,
  input  logic [4:0]  exccode_i,
  input  logic        bd_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] badvaddr_i,
  input  logic        eret_i,
  input  logic        mtc0_we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] epc_o,
  output logic        int_req_o
);

  logic [31:0] badvaddr_q, count_q, compare_q, epc_q;
  logic        tick_q;
  logic [7:0]  im_q;
  logic        exl_q, ie_q;
  logic        bd_q, ti_q;
  logic [5:0]  ip_hw_q;   // Cause.IP[7:2]
  logic [1:0]  ip_sw_q;   // Cause.IP[1:0]
  logic [4:0]  exccode_q;
  logic [31:0] count_d;

  // An MTC0 to Count overrides the half-rate increment
  always_comb begin
    count_d = count_q;
    if (mtc0_we_i && addr_i == CP0_COUNT) count_d = wdata_i;
    else if (tick_q)                      count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q     <= 1'b0;
      count_q    <= '0;
      compare_q  <= '0;
      ti_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      im_q       <= CP0_STATUS_RST[15:8];
      exl_q      <= CP0_STATUS_RST[1];
      ie_q       <= CP0_STATUS_RST[0];
    end else begin
      tick_q  <= ~tick_q;
      count_q <= count_d;
      // Clearing TI by writing Compare wins over a same-cycle match
      if (mtc0_we_i && addr_i == CP0_COMPARE) begin
        compare_q <= wdata_i;
        ti_q      <= 1'b0;
      end else if (count_q == compare_q) begin
        ti_q      <= 1'b1;
      end
      ip_hw_q <= {ext_int_i[5] | ti_q, ext_int_i[4:0]};
      if (ex_i) begin
        exl_q     <= 1'b1;
        exccode_q <= exccode_i;
        // Nested exceptions keep the original EPC/BD
        if (!exl_q) begin
          epc_q <= bd_i ? pc_i - 32'd4 : pc_i;
          bd_q  <= bd_i;
        end
        if (exccode_i == EXC_ADEL || exccode_i == EXC_ADES) badvaddr_q <= badvaddr_i;
      end else begin
        if (eret_i) exl_q <= 1'b0;
        if (mtc0_we_i) begin
          case (addr_i)
            CP0_STATUS: begin
              im_q  <= wdata_i[15:8];
              exl_q <= wdata_i[1];
              ie_q  <= wdata_i[0];
            end
            CP0_CAUSE: ip_sw_q <= wdata_i[9:8];
            CP0_EPC:   epc_q   <= wdata_i;
            default:   ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      CP0_BADVADDR: rdata_o = badvaddr_q;
      CP0_COUNT:    rdata_o = count_q;
      CP0_COMPARE:  rdata_o = compare_q;
      CP0_STATUS:   rdata_o = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
      CP0_CAUSE:    rdata_o = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};
      CP0_EPC:      rdata_o = epc_q;
      default:      rdata_o = '0;
    endcase
  end

  assign epc_o     = epc_q;
  assign int_req_o = (|({ip_hw_q, ip_sw_q} & im_q)) && ie_q && !exl_q;

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage. Holds the MEM->WB pipeline register, gates
// register-file commits, resolves exceptions/interrupts/ERET into a flush
// with redirect PC, and drives the trace-compare debug port.
//   ms_to_ws_valid/bus : incoming instruction
//   ws_allowin         : always ready
//   ws_to_rf_bus       : {rf_we, waddr, wdata} to regfile and bypass
//   ws_valid_o         : WB occupied (decode hazard checks)
//   ws_cancel/flush_pc : pipeline flush and its target
//   ext_int            : hardware interrupts
//   debug_wb_*         : committed instruction trace
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY       = 32'hBFC0_0380,
  parameter logic [31:0] CP0_STATUS_RST = 32'h0040_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0]  ms_to_ws_bus,
  output logic                        ws_allowin,
  output logic [WS_TO_RF_BUS_WD-1:0]  ws_to_rf_bus,
  output logic                        ws_valid_o,
  output logic                        ws_cancel,
  output logic [31:0]                 ws_flush_pc,
  input  logic [5:0]                  ext_int,
  output logic [31:0]                 debug_wb_pc,
  output logic [3:0]                  debug_wb_rf_wen,
  output logic [4:0]                  debug_wb_rf_wnum,
  output logic [31:0]                 debug_wb_rf_wdata
);

  ms_ws_bus_t  bus_q;
  logic        ws_valid_q, ws_valid_d;
  logic        ws_ready_go;
  logic        int_req, ws_ex, eret_commit, mtc0_we;
  logic [4:0]  ex_code;
  logic [31:0] cp0_rdata, epc;
  logic [3:0]  rf_we;
  logic [31:0] rf_wdata;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = !ws_valid_q || ws_ready_go;
  // Anything offered while we flush belongs to the cancelled path
  assign ws_valid_d  = ms_to_ws_valid && !ws_cancel;

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      bus_q      <= '0;
    end else if (ws_allowin) begin
      ws_valid_q <= ws_valid_d;
      if (ms_to_ws_valid) bus_q <= ms_ws_bus_t'(ms_to_ws_bus);
    end
  end

  assign ws_ex       = ws_valid_q && (bus_q.ex || int_req);
  assign ex_code     = int_req ? EXC_INT : bus_q.exccode;
  assign eret_commit = ws_valid_q && bus_q.eret && !ws_ex;
  assign mtc0_we     = ws_valid_q && bus_q.mtc0 && !ws_ex;
  assign ws_cancel   = ws_valid_q && (ws_ex || bus_q.eret);
  assign ws_flush_pc = ws_ex ? EX_ENTRY : epc;

  cp0_regs #(.CP0_STATUS_RST(CP0_STATUS_RST)) u_cp0 (
    .clk        (clk),
    .reset      (reset),
    .ext_int_i  (ext_int),
    .ex_i       (ws_ex),
    .exccode_i  (ex_code),
    .bd_i       (bus_q.bd),
    .pc_i       (bus_q.pc),
    .badvaddr_i (bus_q.badvaddr),
    .eret_i     (eret_commit),
    .mtc0_we_i  (mtc0_we),
    .addr_i     (bus_q.cp0_addr),
    .wdata_i    (bus_q.cp0_wdata),
    .rdata_o    (cp0_rdata),
    .epc_o      (epc),
    .int_req_o  (int_req)
  );

  assign rf_we        = (ws_valid_q && !ws_ex) ? bus_q.rf_we : 4'b0;
  assign rf_wdata     = bus_q.res_from_cp0 ? cp0_rdata : bus_q.result;
  assign ws_to_rf_bus = {rf_we, bus_q.dest, rf_wdata};
  assign ws_valid_o   = ws_valid_q;

  assign debug_wb_pc       = bus_q.pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = bus_q.dest;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_valid;
  ms_ws_bus_t  ms_bus;
  logic        ws_allowin;
  logic [40:0] ws_to_rf_bus;
  logic        ws_valid_o, ws_cancel;
  logic [31:0] ws_flush_pc;
  logic [5:0]  ext_int;
  logic [31:0] dbg_pc, dbg_wdata;
  logic [3:0]  dbg_wen;
  logic [4:0]  dbg_wnum;

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_to_ws_valid    (ms_valid),
    .ms_to_ws_bus      (ms_bus),
    .ws_allowin        (ws_allowin),
    .ws_to_rf_bus      (ws_to_rf_bus),
    .ws_valid_o        (ws_valid_o),
    .ws_cancel         (ws_cancel),
    .ws_flush_pc       (ws_flush_pc),
    .ext_int           (ext_int),
    .debug_wb_pc       (dbg_pc),
    .debug_wb_rf_wen   (dbg_wen),
    .debug_wb_rf_wnum  (dbg_wnum),
    .debug_wb_rf_wdata (dbg_wdata)
  );

  typedef struct {
    ms_ws_bus_t  b;
    logic [3:0]  we;
    logic [31:0] wd;
    logic        cancel;
    logic [31:0] fpc;
  } vec_t;

  localparam logic [31:0] EXV = 32'hBFC0_0380;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic ms_ws_bus_t f_alu(input logic [31:0] pc, input logic [3:0] we,
                                       input logic [4:0] dest, input logic [31:0] res);
    ms_ws_bus_t b = '0;
    b.pc = pc; b.rf_we = we; b.dest = dest; b.result = res;
    return b;
  endfunction

  function automatic ms_ws_bus_t f_mfc0(input logic [31:0] pc, input logic [7:0] a);
    ms_ws_bus_t b = f_alu(pc, 4'hF, 5'd2, 32'hFFFF_FFFF);
    b.res_from_cp0 = 1'b1; b.cp0_addr = a;
    return b;
  endfunction

  function automatic ms_ws_bus_t f_mtc0(input logic [31:0] pc, input logic [7:0] a, input logic [31:0] d);
    ms_ws_bus_t b = '0;
    b.pc = pc; b.mtc0 = 1'b1; b.cp0_addr = a; b.cp0_wdata = d;
    return b;
  endfunction

  function automatic ms_ws_bus_t f_ex(input logic [31:0] pc, input logic [4:0] code,
                                      input logic bd, input logic [31:0] bva);
    ms_ws_bus_t b = '0;
    b.pc = pc; b.ex = 1'b1; b.exccode = code; b.bd = bd; b.badvaddr = bva;
    return b;
  endfunction

  function automatic ms_ws_bus_t f_eret(input logic [31:0] pc);
    ms_ws_bus_t b = '0;
    b.pc = pc; b.eret = 1'b1;
    return b;
  endfunction

  function automatic vec_t mkv(input ms_ws_bus_t b, input logic [3:0] we, input logic [31:0] wd,
                               input logic cancel, input logic [31:0] fpc);
    vec_t v;
    v.b = b; v.we = we; v.wd = wd; v.cancel = cancel; v.fpc = fpc;
    return v;
  endfunction

  // Issue one instruction, check it while it sits in WB, then idle one cycle
  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    ms_valid = 1'b1; ms_bus = v.b;
    @(posedge clk); #1;
    ms_valid = 1'b0;
    check({nm, " valid"}, 64'(ws_valid_o), 64'd1);
    check({nm, " rfbus"}, 64'(ws_to_rf_bus), 64'({v.we, v.b.dest, v.wd}));
    check({nm, " cancel"}, 64'(ws_cancel), 64'(v.cancel));
    if (v.cancel) check({nm, " flush_pc"}, 64'(ws_flush_pc), 64'(v.fpc));
    check({nm, " dbg_pc"}, 64'(dbg_pc), 64'(v.b.pc));
    check({nm, " dbg_wen"}, 64'(dbg_wen), 64'(v.we));
    check({nm, " dbg_wnum"}, 64'(dbg_wnum), 64'(v.b.dest));
    check({nm, " dbg_wdata"}, 64'(dbg_wdata), 64'(v.wd));
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vt[$];
    ms_ws_bus_t b;
    logic [31:0] pc;
    logic got;

    reset = 1'b1; ms_valid = 1'b0; ms_bus = '0; ext_int = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst valid", 64'(ws_valid_o), 64'd0);
    check("rst rf_we", 64'(ws_to_rf_bus[40:37]), 64'd0);
    check("rst dbg_wen", 64'(dbg_wen), 64'd0);
    check("rst cancel", 64'(ws_cancel), 64'd0);
    check("rst allowin", 64'(ws_allowin), 64'd1);
    @(negedge clk); reset = 1'b0;

    vt.push_back(mkv(f_mfc0(32'hBFC0_1000, CP0_STATUS), 4'hF, 32'h0040_0000, 0, 0));
    vt.push_back(mkv(f_mfc0(32'hBFC0_1004, CP0_EPC), 4'hF, 32'h0, 0, 0));
    vt.push_back(mkv(f_mtc0(32'hBFC0_1008, CP0_COMPARE, 32'hFFFF_FFFF), 4'h0, 32'h0, 0, 0));
    vt.push_back(mkv(f_mfc0(32'hBFC0_100C, CP0_CAUSE), 4'hF, 32'h0, 0, 0));
    vt.push_back(mkv(f_alu(32'hBFC0_0000, 4'hF, 5'd3, 32'h1234_5678), 4'hF, 32'h1234_5678, 0, 0));
    vt.push_back(mkv(f_alu(32'hBFC0_0004, 4'hC, 5'd7, 32'hAABB_CCDD), 4'hC, 32'hAABB_CCDD, 0, 0));
    b = f_alu(32'hBFC0_0010, 4'hC, 5'd7, 32'hAABB_CCDD); b.ex = 1'b1; b.exccode = EXC_OV;
    vt.push_back(mkv(b, 4'h0, 32'hAABB_CCDD, 1, EXV));
    vt.push_back(mkv(f_mfc0(32'hBFC0_1010, CP0_CAUSE), 4'hF, 32'h0000_0030, 0, 0));
    vt.push_back(mkv(f_mfc0(32'hBFC0_1014, CP0_STATUS), 4'hF, 32'h0040_0002, 0, 0));
    vt.push_back(mkv(f_eret(32'hBFC0_1018), 4'h0, 32'h0, 1, 32'hBFC0_0010));
    vt.push_back(mkv(f_mfc0(32'hBFC0_101C, CP0_STATUS), 4'hF, 32'h0040_0000, 0, 0));
    vt.push_back(mkv(f_ex(32'hBFC0_0104, EXC_SYS, 1'b1, 32'h0), 4'h0, 32'h0, 1, EXV));
    vt.push_back(mkv(f_mfc0(32'hBFC0_1020, CP0_EPC), 4'hF, 32'hBFC0_0100, 0, 0));
    vt.push_back(mkv(f_mfc0(32'hBFC0_1024, CP0_CAUSE), 4'hF, 32'h8000_0020, 0, 0));
    vt.push_back(mkv(f_mfc0(32'hBFC0_1028, CP0_STATUS), 4'hF, 32'h0040_0002, 0, 0));
    vt.push_back(mkv(f_eret(32'hBFC0_102C), 4'h0, 32'h0, 1, 32'hBFC0_0100));
    vt.push_back(mkv(f_ex(32'hBFC0_0200, EXC_ADEL, 1'b0, 32'h0000_0003), 4'h0, 32'h0, 1, EXV));
    vt.push_back(mkv(f_mfc0(32'hBFC0_1030, CP0_BADVADDR), 4'hF, 32'h0000_0003, 0, 0));
    vt.push_back(mkv(f_mfc0(32'hBFC0_1034, CP0_CAUSE), 4'hF, 32'h0000_0010, 0, 0));
    vt.push_back(mkv(f_eret(32'hBFC0_1038), 4'h0, 32'h0, 1, 32'hBFC0_0200));
    vt.push_back(mkv(f_mtc0(32'hBFC0_103C, CP0_EPC, 32'h0000_1234), 4'h0, 32'h0, 0, 0));
    vt.push_back(mkv(f_mfc0(32'hBFC0_1040, CP0_EPC), 4'hF, 32'h0000_1234, 0, 0));
    vt.push_back(mkv(f_mtc0(32'hBFC0_1044, CP0_STATUS, 32'hFFFF_FF00), 4'h0, 32'h0, 0, 0));
    vt.push_back(mkv(f_mfc0(32'hBFC0_1048, CP0_STATUS), 4'hF, 32'h0040_FF00, 0, 0));
    vt.push_back(mkv(f_mtc0(32'hBFC0_104C, CP0_STATUS, 32'h0), 4'h0, 32'h0, 0, 0));
    vt.push_back(mkv(f_mtc0(32'hBFC0_1050, CP0_CAUSE, 32'hFFFF_FFFF), 4'h0, 32'h0, 0, 0));
    vt.push_back(mkv(f_mfc0(32'hBFC0_1054, CP0_CAUSE), 4'hF, 32'h0000_0310, 0, 0));
    vt.push_back(mkv(f_mtc0(32'hBFC0_1058, CP0_CAUSE, 32'h0), 4'h0, 32'h0, 0, 0));
    vt.push_back(mkv(f_mfc0(32'hBFC0_105C, 8'h01), 4'hF, 32'h0, 0, 0));
    b = f_mtc0(32'hBFC0_0300, CP0_EPC, 32'h0000_DEAD); b.ex = 1'b1; b.exccode = EXC_RI;
    vt.push_back(mkv(b, 4'h0, 32'h0, 1, EXV));
    vt.push_back(mkv(f_mfc0(32'hBFC0_1060, CP0_EPC), 4'hF, 32'hBFC0_0300, 0, 0));
    vt.push_back(mkv(f_eret(32'hBFC0_1064), 4'h0, 32'h0, 1, 32'hBFC0_0300));

    foreach (vt[i]) run_vec(vt[i], $sformatf("v%0d", i));

    // Timer interrupt: Compare first so the old Count cannot re-trigger TI
    run_vec(mkv(f_mtc0(32'hBFC0_2000, CP0_COMPARE, 32'd10), 4'h0, 32'h0, 0, 0), "t_cmp");
    run_vec(mkv(f_mtc0(32'hBFC0_2004, CP0_COUNT, 32'd0), 4'h0, 32'h0, 0, 0), "t_cnt");
    run_vec(mkv(f_mtc0(32'hBFC0_2008, CP0_STATUS, 32'h0000_8001), 4'h0, 32'h0, 0, 0), "t_sts");
    pc = 32'hBFC0_0400; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      ms_valid = 1'b1; ms_bus = f_alu(pc, 4'hF, 5'd1, 32'(i));
      @(posedge clk); #1;
      if (ws_cancel) got = 1'b1;
      else pc = pc + 32'd4;
    end
    check("int taken", 64'(got), 64'd1);
    check("int rf_we", 64'(ws_to_rf_bus[40:37]), 64'd0);
    check("int dbg_wen", 64'(dbg_wen), 64'd0);
    check("int flush_pc", 64'(ws_flush_pc), 64'(EXV));
    // ms_valid still high: this offer coincides with the flush and must be dropped
    @(posedge clk); #1;
    ms_valid = 1'b0;
    check("drop valid", 64'(ws_valid_o), 64'd0);
    check("drop dbg_wen", 64'(dbg_wen), 64'd0);
    @(posedge clk); #1;
    run_vec(mkv(f_mfc0(32'hBFC0_2010, CP0_CAUSE), 4'hF, 32'h4000_8000, 0, 0), "int cause");
    run_vec(mkv(f_mfc0(32'hBFC0_2014, CP0_EPC), 4'hF, pc, 0, 0), "int epc");
    run_vec(mkv(f_mtc0(32'hBFC0_2018, CP0_COMPARE, 32'hFFFF_FFFF), 4'h0, 32'h0, 0, 0), "ti clr");
    run_vec(mkv(f_mfc0(32'hBFC0_201C, CP0_CAUSE), 4'hF, 32'h0, 0, 0), "ti cause");
    run_vec(mkv(f_mtc0(32'hBFC0_2020, CP0_STATUS, 32'h0), 4'h0, 32'h0, 0, 0), "sts clr");
    run_vec(mkv(f_eret(32'hBFC0_2024), 4'h0, 32'h0, 1, pc), "int eret");

    // Reset arriving with an instruction: nothing commits, CP0 returns to reset
    @(negedge clk);
    ms_valid = 1'b1; ms_bus = f_alu(32'hBFC0_3000, 4'hF, 5'd9, 32'h5555_AAAA); reset = 1'b1;
    @(posedge clk); #1;
    ms_valid = 1'b0;
    check("rmid valid", 64'(ws_valid_o), 64'd0);
    check("rmid rf_we", 64'(ws_to_rf_bus[40:37]), 64'd0);
    check("rmid dbg_wen", 64'(dbg_wen), 64'd0);
    @(negedge clk); reset = 1'b0;
    run_vec(mkv(f_mfc0(32'hBFC0_3004, CP0_EPC), 4'hF, 32'h0, 0, 0), "rmid epc");
    run_vec(mkv(f_mfc0(32'hBFC0_3008, CP0_STATUS), 4'hF, 32'h0040_0000, 0, 0), "rmid sts");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
